fpga_cfg_readback: RTL and testbench
====================================

# fpga_cfg_readback

Configuration readback engine for the `fpga` fabric. It walks the configuration frames in the same order the bitstream loader writes them. For each frame it asserts a one-hot read enable, captures the returned frame, and streams it out as fixed-width words on a valid/ready interface. Verification uses it to compare fabric state against the `.bs` file; debug logic uses it to dump live configuration.

## Interface
Parameters:
- `FRAME_W`, 224, bits per configuration frame (width of fabric config data)
- `NUM_FRAMES`, 245, number of frames (width of one-hot enable)
- `OUT_W`, 32, output word width; `FRAME_W` need not be a multiple

Ports:
- `clock` in 1: single clock; all logic on rising edge
- `rst` in 1: asynchronous, active-high reset
- `start` in 1: one-cycle request to begin a full readback; ignored while `busy`
- `busy` out 1: high from the cycle after an accepted `start` until `done`
- `done` out 1: one-cycle pulse after the final word handshake
- `cfg_rd_en` out `NUM_FRAMES`: one-hot frame select to fabric; all-zero when not reading
- `cfg_rd_data` in `FRAME_W`: frame contents from fabric; valid while `cfg_rd_en` is held
- `out_data` out `OUT_W`: readback word
- `out_valid` out 1: `out_data` valid
- `out_ready` in 1: consumer accepts word when `out_valid && out_ready`
- `out_last` out 1: marks final word of the readback
- `frame_idx` out `$clog2(NUM_FRAMES)`: index of frame currently selected/streaming

## Operation
- `WPF` = ceil(`FRAME_W`/`OUT_W`) = 7 for the defaults.
- Word k of a frame = frame bits [k·OUT_W+OUT_W-1 : k·OUT_W]. Word 0 is sent first.
- Bits beyond `FRAME_W` in the last word are zero.
- Frames are sent in index order 0..NUM_FRAMES-1. Frame i uses `cfg_rd_en` = 1<<i, matching the loader's left-shift order.
- FSM states: IDLE, SELECT, CAPTURE, SEND, DONE.
- IDLE: `start` → SELECT with `frame_idx`=0.
- SELECT (1 cycle): drive `cfg_rd_en`=1<<frame_idx → CAPTURE.
- CAPTURE (1 cycle): keep `cfg_rd_en`. Latch `cfg_rd_data` into the frame buffer at end of cycle. Word counter = 0 → SEND.
- SEND:
  - `cfg_rd_en` = 0 and `out_valid` = 1.
  - On handshake, advance the word counter.
  - After word WPF-1 of a non-final frame: increment `frame_idx` → SELECT.
  - After the final frame's last word (or the checksum word, if enabled): → DONE.
- DONE (1 cycle): `done`=1, `busy`=0 → IDLE.
- `out_data` and `out_valid` stay stable while stalled: no change until handshake.
- `out_last`=1 only with the final word of the stream.
- `start` during `busy` has no effect. `start` asserted in the DONE cycle is ignored.

## Timing
- Reset values: state IDLE.
  - `cfg_rd_en`=0, `out_valid`=0, `out_last`=0, `out_data`=0.
  - `busy`=0, `done`=0, `frame_idx`=0.
  - Checksum accumulator 0.
- Latency: `start` sampled at edge 0. `cfg_rd_en` asserts after edge 0, stays through edge 2. `out_valid` first high after edge 2.
- Per-frame overhead is 2 cycles (SELECT+CAPTURE) between the last handshake of frame i and first `out_valid` of frame i+1.
- Minimum total cycles, `out_ready` tied high: NUM_FRAMES·(WPF+2) plus checksum word if enabled, plus 1 DONE cycle.
- `rst` mid-operation: immediate return to reset values. `cfg_rd_en` drops asynchronously and the partial stream is abandoned.

## Configuration
- `FPGA_CFG_RB_CHECKSUM_EN` defined:
  - After the last data word, one extra word is sent: the sum modulo 2^OUT_W of all data words, padding included.
  - This word carries `out_last`. The last data word does not.
  - The accumulator clears on accepted `start`.
- Undefined: no accumulator is built, and `out_last` is on the final data word.

## Structure
- Package `fpga_cfg_pkg`:
  - default `FRAME_W`/`NUM_FRAMES`/`OUT_W` constants
  - `WPF` computation function
  - `cfg_rb_state_t` enum, shared with the bitstream loader
- One sub-module, `fpga_cfg_rb_serializer`: frame buffer plus word counter, padding, and word mux; `load`/`advance` inputs and `word`/`last_word` outputs.
- Top holds the FSM, `frame_idx`, one-hot generation, and the checksum.

## Test plan
- Defaults, fabric model returns frame i = {FRAME_W/8{8'(i)}}, `out_ready`=1, start: 1715 words, frame 0 word 0 = 0x00000000, frame 3 word 6 = 0x03030303; `done` at expected cycle.
- Padding: `FRAME_W`=40, `OUT_W`=32, frame = 40'hFF_1234_5678: words 0x12345678 then 0x000000FF.
- Backpressure: `out_ready` toggled pseudo-randomly: identical word sequence, `out_data` stable during stalls, `cfg_rd_en` zero while in SEND.
- `start` pulsed mid-readback and in DONE cycle: ignored; single `done` pulse; stream unchanged.
- `rst` asserted during frame 10 word 3: next sample `cfg_rd_en`=0, `out_valid`=0, `busy`=0. Fresh `start` restarts at frame 0 word 0.
- With `FPGA_CFG_RB_CHECKSUM_EN`, all frames 0x…01 per word: final word = 1715 mod 2^32 = 0x000006B3 with `out_last`=1. Without it, `out_last` is on word 1715.

Source files
------------

// File: rtl/fpga_cfg_pkg.sv
// Shared constants, word-count helper and readback FSM states for the fpga config path.
package fpga_cfg_pkg;

  localparam int unsigned CFG_FRAME_W    = 224;
  localparam int unsigned CFG_NUM_FRAMES = 245;
  localparam int unsigned CFG_OUT_W      = 32;

  // Output words needed to carry one frame (last word zero padded).
  function automatic int unsigned calc_wpf(input int unsigned frame_w, input int unsigned out_w);
    return (frame_w + out_w - 1) / out_w;
  endfunction

  typedef enum logic [2:0] {
    CFG_RB_IDLE    = 3'd0,
    CFG_RB_SELECT  = 3'd1,
    CFG_RB_CAPTURE = 3'd2,
    CFG_RB_SEND    = 3'd3,
    CFG_RB_DONE    = 3'd4
  } cfg_rb_state_t;

endpackage

// File: rtl/fpga_cfg_rb_serializer.sv
// Frame buffer that slices a captured frame into OUT_W words, word 0 first.
// The buffer shifts down one word per advance so the current word is always
// the low slice; a one-hot position vector tracks the word count.
module fpga_cfg_rb_serializer
  import fpga_cfg_pkg::*;
#(
  parameter int unsigned FRAME_W = CFG_FRAME_W,
  parameter int unsigned OUT_W   = CFG_OUT_W
) (
  input  logic               clock,
  input  logic               rst,
  input  logic               load,
  input  logic [FRAME_W-1:0] frame_in,
  input  logic               load_word,
  input  logic [OUT_W-1:0]   word_in,
  input  logic               advance,
  output logic [OUT_W-1:0]   word,
  output logic               last_word,
  output logic               next_last
);

  localparam int unsigned WPF   = calc_wpf(FRAME_W, OUT_W);
  localparam int unsigned PAD_W = WPF * OUT_W;
  localparam int unsigned POS_W = WPF + 1;

  logic [PAD_W-1:0] frame_q;
  logic [POS_W-1:0] pos_q;

  assign word      = frame_q[OUT_W-1:0];
  assign last_word = pos_q[0];
  assign next_last = pos_q[1];

  // Load a frame (or a single trailing word) and shift one word per advance.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      frame_q <= '0;
      pos_q   <= '0;
    end else if (load) begin
      frame_q <= PAD_W'(frame_in);
      pos_q   <= POS_W'(1) << (WPF - 1);
    end else if (load_word) begin
      frame_q <= PAD_W'(word_in);
      pos_q   <= POS_W'(1);
    end else if (advance) begin
      frame_q <= frame_q >> OUT_W;
      pos_q   <= pos_q >> 1;
    end
  end

endmodule

// File: rtl/fpga_cfg_readback.sv
// Configuration readback engine: selects each frame one-hot, captures it and
// streams it as OUT_W words on a valid/ready port.
// Optional feature: define FPGA_CFG_RB_CHECKSUM_EN to append a modulo-2^OUT_W
// sum of all data words as the final (out_last) word.
module fpga_cfg_readback
  import fpga_cfg_pkg::*;
#(
  parameter int unsigned FRAME_W    = CFG_FRAME_W,
  parameter int unsigned NUM_FRAMES = CFG_NUM_FRAMES,
  parameter int unsigned OUT_W      = CFG_OUT_W
) (
  input  logic                          clock,
  input  logic                          rst,
  input  logic                          start,
  output logic                          busy,
  output logic                          done,
  output logic [NUM_FRAMES-1:0]         cfg_rd_en,
  input  logic [FRAME_W-1:0]            cfg_rd_data,
  output logic [OUT_W-1:0]              out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          out_last,
  output logic [$clog2(NUM_FRAMES)-1:0] frame_idx
);

  localparam int unsigned WPF   = calc_wpf(FRAME_W, OUT_W);
  localparam int unsigned IDX_W = $clog2(NUM_FRAMES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_FRAMES - 1);
`ifdef FPGA_CFG_RB_CHECKSUM_EN
  localparam bit CKSUM_EN = 1'b1;
`else
  localparam bit CKSUM_EN = 1'b0;
`endif

  cfg_rb_state_t    state_q, state_nxt;
  logic [IDX_W-1:0] frame_idx_nxt;
  logic             last_nxt;
  logic             ser_load, ser_load_word, ser_advance;
  logic             ser_last, ser_next_last;
  logic [OUT_W-1:0] ser_word, ser_word_in;
  logic             hs_c, final_frame_c;

`ifdef FPGA_CFG_RB_CHECKSUM_EN
  logic [OUT_W-1:0] cksum_q, cksum_nxt, ck_word_c;
  logic             ck_phase_q, ck_phase_nxt;
  assign ck_word_c   = cksum_q + out_data;
  assign ser_word_in = ck_word_c;
`else
  assign ser_word_in = '0;
`endif

  assign hs_c          = out_valid && out_ready;
  assign final_frame_c = (frame_idx == LAST_IDX);
  assign out_data      = ser_word;

  fpga_cfg_rb_serializer #(
    .FRAME_W (FRAME_W),
    .OUT_W   (OUT_W)
  ) u_ser (
    .clock     (clock),
    .rst       (rst),
    .load      (ser_load),
    .frame_in  (cfg_rd_data),
    .load_word (ser_load_word),
    .word_in   (ser_word_in),
    .advance   (ser_advance),
    .word      (ser_word),
    .last_word (ser_last),
    .next_last (ser_next_last)
  );

  // Next-state, frame sequencing and word-stream control.
  always_comb begin
    state_nxt     = state_q;
    frame_idx_nxt = frame_idx;
    last_nxt      = out_last;
    ser_load      = 1'b0;
    ser_load_word = 1'b0;
    ser_advance   = 1'b0;
`ifdef FPGA_CFG_RB_CHECKSUM_EN
    cksum_nxt     = cksum_q;
    ck_phase_nxt  = ck_phase_q;
`endif
    case (state_q)
      CFG_RB_IDLE: begin
        if (start) begin
          state_nxt     = CFG_RB_SELECT;
          frame_idx_nxt = '0;
          last_nxt      = 1'b0;
`ifdef FPGA_CFG_RB_CHECKSUM_EN
          cksum_nxt     = '0;
`endif
        end
      end
      CFG_RB_SELECT: state_nxt = CFG_RB_CAPTURE;
      CFG_RB_CAPTURE: begin
        ser_load  = 1'b1;
        state_nxt = CFG_RB_SEND;
        last_nxt  = final_frame_c && (WPF == 32'd1) && !CKSUM_EN;
      end
      CFG_RB_SEND: begin
        if (hs_c) begin
`ifdef FPGA_CFG_RB_CHECKSUM_EN
          if (ck_phase_q) begin
            ser_advance  = 1'b1;
            ck_phase_nxt = 1'b0;
            last_nxt     = 1'b0;
            state_nxt    = CFG_RB_DONE;
          end else
`endif
          begin
`ifdef FPGA_CFG_RB_CHECKSUM_EN
            cksum_nxt = ck_word_c;
`endif
            if (!ser_last) begin
              ser_advance = 1'b1;
              last_nxt    = final_frame_c && ser_next_last && !CKSUM_EN;
            end else if (!final_frame_c) begin
              ser_advance   = 1'b1;
              frame_idx_nxt = frame_idx + IDX_W'(1);
              state_nxt     = CFG_RB_SELECT;
              last_nxt      = 1'b0;
            end else begin
`ifdef FPGA_CFG_RB_CHECKSUM_EN
              ser_load_word = 1'b1;
              ck_phase_nxt  = 1'b1;
              last_nxt      = 1'b1;
`else
              ser_advance   = 1'b1;
              state_nxt     = CFG_RB_DONE;
              last_nxt      = 1'b0;
`endif
            end
          end
        end
      end
      CFG_RB_DONE: state_nxt = CFG_RB_IDLE;
      default:     state_nxt = CFG_RB_IDLE;
    endcase
  end

  // State and registered outputs, all derived from the next state.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state_q    <= CFG_RB_IDLE;
      frame_idx  <= '0;
      cfg_rd_en  <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
`ifdef FPGA_CFG_RB_CHECKSUM_EN
      cksum_q    <= '0;
      ck_phase_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_nxt;
      frame_idx <= frame_idx_nxt;
      cfg_rd_en <= (state_nxt == CFG_RB_SELECT || state_nxt == CFG_RB_CAPTURE)
                   ? (NUM_FRAMES'(1) << frame_idx_nxt) : '0;
      busy      <= (state_nxt == CFG_RB_SELECT) || (state_nxt == CFG_RB_CAPTURE) ||
                   (state_nxt == CFG_RB_SEND);
      done      <= (state_nxt == CFG_RB_DONE);
      out_valid <= (state_nxt == CFG_RB_SEND);
      out_last  <= last_nxt;
`ifdef FPGA_CFG_RB_CHECKSUM_EN
      cksum_q    <= cksum_nxt;
      ck_phase_q <= ck_phase_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_fpga_cfg_readback.sv
// Scoreboard bench for fpga_cfg_readback (default build and checksum build).
module tb_fpga_cfg_readback;
  import fpga_cfg_pkg::*;

  localparam int unsigned FW  = 224;
  localparam int unsigned NF  = 245;
  localparam int unsigned OW  = 32;
  localparam int unsigned WPF = calc_wpf(FW, OW);
  localparam int unsigned IW  = $clog2(NF);
`ifdef FPGA_CFG_RB_CHECKSUM_EN
  localparam int unsigned CKX = 1;
`else
  localparam int unsigned CKX = 0;
`endif

  logic clock, rst, start, busy, done, out_valid, out_ready, out_last;
  logic [NF-1:0] cfg_rd_en;
  logic [FW-1:0] cfg_rd_data;
  logic [OW-1:0] out_data;
  logic [IW-1:0] frame_idx;

  // Small padding instance: 40-bit frames, two frames
  logic p_start, p_busy, p_done, p_out_valid, p_out_ready, p_out_last;
  logic [1:0]  p_cfg_rd_en;
  logic [39:0] p_cfg_rd_data;
  logic [31:0] p_out_data;
  logic        p_frame_idx;

  fpga_cfg_readback #(.FRAME_W(FW), .NUM_FRAMES(NF), .OUT_W(OW)) dut (
    .clock(clock), .rst(rst), .start(start), .busy(busy), .done(done),
    .cfg_rd_en(cfg_rd_en), .cfg_rd_data(cfg_rd_data), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
    .frame_idx(frame_idx));

  fpga_cfg_readback #(.FRAME_W(40), .NUM_FRAMES(2), .OUT_W(32)) p_dut (
    .clock(clock), .rst(rst), .start(p_start), .busy(p_busy), .done(p_done),
    .cfg_rd_en(p_cfg_rd_en), .cfg_rd_data(p_cfg_rd_data), .out_data(p_out_data),
    .out_valid(p_out_valid), .out_ready(p_out_ready), .out_last(p_out_last),
    .frame_idx(p_frame_idx));

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Fabric models: frame i is every byte equal to i
  always_comb begin
    cfg_rd_data = '0;
    for (int i = 0; i < NF; i++)
      if (cfg_rd_en[i]) cfg_rd_data = {(FW/8){8'(i)}};
  end
  assign p_cfg_rd_data = p_cfg_rd_en[0] ? 40'hFF_1234_5678 :
                         p_cfg_rd_en[1] ? 40'hAB_CDEF_0123 : 40'h0;

  typedef struct packed {
    logic [31:0] data;
    logic        last;
    logic [7:0]  frame;
    logic [7:0]  word;
  } exp_t;
  typedef struct packed {
    logic [31:0] data;
    logic        last;
  } pexp_t;

  exp_t  q[$];
  pexp_t q2[$];
  int checks = 0, errors = 0;
  int accepted = 0, p_accepted = 0, done_cnt = 0;
  logic        stall_prev = 1'b0;
  logic [31:0] prev_data = '0;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic push_readback();
    logic [WPF*OW-1:0] fr;
    logic [OW-1:0] w, sum;
    sum = '0;
    for (int f = 0; f < NF; f++) begin
      fr = (WPF*OW)'({(FW/8){8'(f)}});
      for (int k = 0; k < WPF; k++) begin
        w = fr[k*OW +: OW];
        sum += w;
        q.push_back('{w, (CKX == 0) && (f == NF-1) && (k == WPF-1), 8'(f), 8'(k)});
      end
    end
    if (CKX != 0) q.push_back('{sum, 1'b1, 8'(NF-1), 8'(WPF)});
  endtask

  // Monitor: pops expected words on each handshake, checks stall stability and frame select
  always @(negedge clock) begin
    exp_t e;
    logic [255:0] onehot;
    if (rst) stall_prev = 1'b0;
    else begin
      if (out_valid) begin
        chk("rd_en_in_send", cfg_rd_en, 0);
        if (stall_prev) chk("stall_hold", out_data, prev_data);
        if (out_ready) begin
          stall_prev = 1'b0;
          accepted++;
          if (q.size() == 0) chk("unexpected_word", out_data, 0) ;
          if (q.size() != 0) begin
            e = q.pop_front();
            chk("word_data", out_data, e.data);
            chk("word_last", out_last, e.last);
            if (e.word < 8'(WPF)) chk("word_frame_idx", frame_idx, e.frame);
            if (e.frame == 8'd0 && e.word == 8'd0) chk("f0w0", out_data, 32'h00000000);
            if (e.frame == 8'd3 && e.word == 8'd6) chk("f3w6", out_data, 32'h03030303);
          end
        end else begin
          stall_prev = 1'b1;
          prev_data  = out_data;
        end
      end else begin
        stall_prev = 1'b0;
        if (busy && q.size() != 0) begin
          onehot = 256'(1) << q[0].frame;
          chk("rd_en_onehot", cfg_rd_en, onehot);
        end
      end
      if (done) done_cnt++;
      if (p_out_valid && p_out_ready) begin
        p_accepted++;
        if (q2.size() != 0) begin
          chk("pad_data", p_out_data, q2[0].data);
          chk("pad_last", p_out_last, q2[0].last);
          void'(q2.pop_front());
        end else chk("pad_unexpected", p_out_data, 0);
      end
    end
  end

  // Full readback; optional random backpressure and ignored start pulses
  task automatic run(input bit rnd);
    int n, base;
    base = accepted;
    done_cnt = 0;
    @(posedge clock); #1 start = 1'b1; out_ready = 1'b1;
    @(posedge clock); #1 start = 1'b0;
    n = 0;
    while (!done && n < 12000) begin
      if (rnd) out_ready = ($urandom_range(0, 2) != 0);
      start = (n == 400) || (n == 401);
      @(posedge clock); #1 n++;
    end
    if (!rnd) chk("done_cycle", n, NF*(WPF+2) + CKX);
    start = 1'b1;
    @(posedge clock); #1 start = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    chk("idle_after_done", busy, 0);
    chk("done_pulses", done_cnt, 1);
    chk("word_count", accepted - base, NF*WPF + CKX);
    chk("queue_empty", q.size(), 0);
    q.delete();
  endtask

  initial begin
    int n, base;
    void'($urandom(32'h1234));
    rst = 1'b1; start = 1'b0; out_ready = 1'b0; p_start = 1'b0; p_out_ready = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_rd_en", cfg_rd_en, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_last", out_last, 0);
    chk("rst_data", out_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_frame_idx", frame_idx, 0);
    rst = 1'b0;

    // Padding: 40-bit frames split into two words, upper bits zero
    q2.push_back('{32'h12345678, 1'b0});
    q2.push_back('{32'h000000FF, 1'b0});
    q2.push_back('{32'hCDEF0123, 1'b0});
    q2.push_back('{32'h000000AB, (CKX == 0)});
    if (CKX != 0) q2.push_back('{32'hE0235945, 1'b1});
    @(posedge clock); #1 p_start = 1'b1;
    @(posedge clock); #1 p_start = 1'b0;
    n = 0;
    while (!p_done && n < 100) begin @(posedge clock); #1 n++; end
    chk("pad_done_cycle", n, 2*(2+2) + CKX);
    chk("pad_count", p_accepted, 4 + CKX);
    chk("pad_queue_empty", q2.size(), 0);

    push_readback();
    run(1'b0);
    push_readback();
    run(1'b1);

    // Reset during frame 10 word 3, then a fresh readback from frame 0
    push_readback();
    base = accepted;
    @(posedge clock); #1 start = 1'b1; out_ready = 1'b1;
    @(posedge clock); #1 start = 1'b0;
    n = 0;
    while (accepted != base + 73 && n < 2000) begin @(posedge clock); #1 n++; end
    chk("rst_point_frame", frame_idx, 10);
    chk("rst_point_word", out_data, 32'h0A0A0A0A);
    rst = 1'b1;
    q.delete();
    #1;
    chk("midrst_rd_en", cfg_rd_en, 0);
    chk("midrst_valid", out_valid, 0);
    chk("midrst_busy", busy, 0);
    @(posedge clock); #1 rst = 1'b0;
    push_readback();
    run(1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
